// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit owning the architectural HI/LO registers.
// MULT/DIV complete after a fixed latency; MTHI/MTLO write in a single cycle.
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] in0,
    input  logic [31:0] in1,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    // state   | meaning
    // ST_IDLE | accepting requests; MTHI/MTLO act immediately
    // ST_BUSY | MULT/DIV in flight; counter runs down to completion

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;
    localparam logic [2:0] OP_NONE  = 3'd0;

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(1);

    logic [0:0]       state;
    logic [CNT_W-1:0] count;
    logic [2:0]       op_q;
    logic [31:0]      a_q;
    logic [31:0]      b_q;

    logic signed [63:0] a64;
    logic signed [63:0] b64;
    logic [63:0]        prod_s;
    logic [63:0]        prod_u;
    logic signed [32:0] a33;
    logic signed [32:0] b33;
    logic [31:0]        quot_s;
    logic [31:0]        rem_s;
    logic [31:0]        quot_u;
    logic [31:0]        rem_u;

    logic        res_we;
    logic [31:0] res_hi;
    logic [31:0] res_lo;

    assign busy = (state == ST_BUSY);

    assign a64    = {{32{a_q[31]}}, a_q};
    assign b64    = {{32{b_q[31]}}, b_q};
    assign prod_s = a64 * b64;
    assign prod_u = {32'd0, a_q} * {32'd0, b_q};

    // 33-bit signed divide so 0x80000000 / -1 yields 0x80000000 without overflow
    assign a33    = {a_q[31], a_q};
    assign b33    = {b_q[31], b_q};
    assign quot_s = 32'(a33 / b33);
    assign rem_s  = 32'(a33 % b33);
    assign quot_u = a_q / b_q;
    assign rem_u  = a_q % b_q;

    always_comb begin
        res_we = 1'b1;
        res_hi = hi;
        res_lo = lo;
        case (op_q)
            OP_MULT:  {res_hi, res_lo} = prod_s;
            OP_MULTU: {res_hi, res_lo} = prod_u;
            OP_DIV: begin
                if (b_q == 32'd0) begin
                    res_we = 1'b0;
                end else begin
                    res_hi = rem_s;
                    res_lo = quot_s;
                end
            end
            OP_DIVU: begin
                if (b_q == 32'd0) begin
                    res_we = 1'b0;
                end else begin
                    res_hi = rem_u;
                    res_lo = quot_u;
                end
            end
            default: res_we = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            count <= '0;
            op_q  <= OP_NONE;
            a_q   <= '0;
            b_q   <= '0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        case (md_op)
                            OP_MULT, OP_MULTU: begin
                                op_q  <= md_op;
                                a_q   <= in0;
                                b_q   <= in1;
                                count <= MULT_LOAD;
                                state <= ST_BUSY;
                            end
                            OP_DIV, OP_DIVU: begin
                                op_q  <= md_op;
                                a_q   <= in0;
                                b_q   <= in1;
                                count <= DIV_LOAD;
                                state <= ST_BUSY;
                            end
                            OP_MTHI: hi <= in0;
                            OP_MTLO: lo <= in0;
                            default: ;
                        endcase
                    end
                end
                default: begin
                    if (count == CNT_LAST) begin
                        state <= ST_IDLE;
                        count <= '0;
                        if (res_we) begin
                            hi <= res_hi;
                            lo <= res_lo;
                        end
                    end else begin
                        count <= count - CNT_LAST;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: stimulus pushes expected completions,
// a negedge monitor checks busy length, HI/LO stability and final results.
module tb_mult_div_unit;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] in0;
    logic [31:0] in1;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] old_hi;
        logic [31:0] old_lo;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          len;
    } entry_t;

    entry_t sb[$];
    logic [31:0] mhi;
    logic [31:0] mlo;

    mult_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .start(start), .md_op(md_op),
        .in0(in0), .in1(in1), .busy(busy), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference arithmetic from the architectural definitions
    task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] rh, output logic [31:0] rl, output int len);
        longint sa, sb_, q, r, p;
        longint unsigned ua, ub, pu;
        sa = longint'($signed(a));
        sb_ = longint'($signed(b));
        ua = longint'(a);
        ub = longint'(b);
        rh = mhi;
        rl = mlo;
        len = (op <= 3'd2) ? MC : DC;
        case (op)
            3'd1: begin p = sa * sb_; rh = p[63:32]; rl = p[31:0]; end
            3'd2: begin pu = ua * ub; rh = pu[63:32]; rl = pu[31:0]; end
            3'd3: if (b != 0) begin q = sa / sb_; r = sa % sb_; rh = r[31:0]; rl = q[31:0]; end
            3'd4: if (b != 0) begin q = longint'(ua / ub); r = longint'(ua % ub); rh = r[31:0]; rl = q[31:0]; end
            default: ;
        endcase
    endtask

    // Monitor: counts busy cycles, checks HI/LO hold while busy, scores completion
    int  bcnt = 0;
    logic pbusy = 1'b0;
    always @(negedge clk) begin
        if (busy === 1'b1) begin
            bcnt++;
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_busy: got busy=1 expected no pending op");
            end else begin
                chk("hold_hi", hi, sb[0].old_hi);
                chk("hold_lo", lo, sb[0].old_lo);
            end
        end else if (pbusy) begin
            if (sb.size() != 0) begin
                entry_t e;
                e = sb.pop_front();
                chk("done_hi", hi, e.exp_hi);
                chk("done_lo", lo, e.exp_lo);
                chk("busy_len", 32'(bcnt), 32'(e.len));
            end
            bcnt = 0;
        end
        pbusy = busy;
    end

    // Caller is just after a negedge; returns just after the following negedge
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        entry_t e;
        logic [31:0] rh, rl;
        int len;
        if (op >= 3'd1 && op <= 3'd4) begin
            model(op, a, b, rh, rl, len);
            e.old_hi = mhi; e.old_lo = mlo; e.exp_hi = rh; e.exp_lo = rl; e.len = len;
            sb.push_back(e);
            mhi = rh; mlo = rl;
        end
        start = 1'b1; md_op = op; in0 = a; in1 = b;
        @(negedge clk);
        start = 1'b0; md_op = 3'd0;
        if (op == 3'd5) mhi = a;
        if (op == 3'd6) mlo = a;
        if (op >= 3'd1 && op <= 3'd4) chk("accept_busy", 32'(busy), 32'd1);
        else begin
            chk("imm_busy", 32'(busy), 32'd0);
            chk("imm_hi", hi, mhi);
            chk("imm_lo", lo, mlo);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (busy !== 1'b0) begin
            checks++; errors++;
            $display("FAIL idle_timeout: got busy=%b expected 0", busy);
        end
        @(negedge clk);
    endtask

    initial begin
        logic [2:0] op;
        logic [31:0] a, b;
        reset = 1'b1; start = 1'b0; md_op = 3'd0; in0 = '0; in1 = '0;
        mhi = '0; mlo = '0;
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);

        issue(3'd5, 32'h12345678, 32'h0);
        issue(3'd6, 32'h9ABCDEF0, 32'h0);

        issue(3'd1, 32'hFFFFFFFE, 32'h3); wait_idle();
        issue(3'd2, 32'hFFFFFFFE, 32'h3); wait_idle();
        issue(3'd3, 32'hFFFFFFF9, 32'h2); wait_idle();
        issue(3'd4, 32'h7, 32'h2); wait_idle();
        issue(3'd3, 32'h80000000, 32'hFFFFFFFF); wait_idle();

        issue(3'd5, 32'hAAAA, 32'h0);
        issue(3'd6, 32'hBBBB, 32'h0);
        issue(3'd4, 32'h1234, 32'h0); wait_idle();
        chk("dz_hi", hi, 32'hAAAA);
        chk("dz_lo", lo, 32'hBBBB);

        // Starts while busy must be ignored; back-to-back MULTU afterwards
        issue(3'd1, 32'd3, 32'd4);
        start = 1'b1; md_op = 3'd6; in0 = 32'h55;
        @(negedge clk);
        md_op = 3'd3; in0 = 32'h777; in1 = 32'h5;
        @(negedge clk);
        start = 1'b0; md_op = 3'd0; in0 = 32'hDEAD; in1 = 32'hBEEF;
        while (busy === 1'b1) @(negedge clk);
        issue(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF); wait_idle();

        // Reset aborts a divide on its 4th busy cycle
        issue(3'd3, 32'd100, 32'd7);
        sb[0].exp_hi = 32'd0; sb[0].exp_lo = 32'd0; sb[0].len = 4;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        mhi = '0; mlo = '0;
        chk("abort_busy", 32'(busy), 32'd0);
        repeat (15) @(negedge clk);
        chk("abort_hi", hi, 32'd0);
        chk("abort_lo", lo, 32'd0);

        issue(3'd6, 32'h1111, 32'h0);
        reset = 1'b1; start = 1'b1; md_op = 3'd1; in0 = 32'd9; in1 = 32'd9;
        @(negedge clk);
        reset = 1'b0; start = 1'b0; md_op = 3'd0;
        mlo = '0;
        chk("rst_win_busy", 32'(busy), 32'd0);
        chk("rst_win_lo", lo, 32'd0);

        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 3));
            if ($urandom_range(0, 5) == 0) a = 32'h80000000;
            if ($urandom_range(0, 5) == 0) b = 32'hFFFFFFFF;
            issue(op, a, b);
            wait_idle();
        end

        repeat (3) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
